eth_rx_deframer: RTL

Synthesisable, width-parametrised Ethernet frame receiver for the PHY-side symbol stream (RMII DW=2, MII DW=4, GMII DW=8).
- Detects preamble/SFD, assembles symbols LSB-first into bytes and strips the 4-byte FCS through a delay line.
- Checks FCS, length and alignment, then emits the payload bytes followed by one status strobe per frame.
- Sits between the PHY pins and the MAC RX FIFO; reuses the existing crc32 block.

---
 rtl/eth_defs.sv | 22 ++
 rtl/crc32.sv | 30 +++
 rtl/eth_fcs_delay.sv | 34 +++
 rtl/eth_rx_deframer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/eth_defs.sv
// Shared definitions for the Ethernet RX deframer: preamble/SFD pattern,
// frame size limits, FSM state encoding and byte-swap helper.
package eth_defs;

  localparam logic [63:0] ETH_PRE_SFD   = 64'hD555555555555555;
  localparam int unsigned ETH_MIN_FRAME = 64;
  localparam int unsigned ETH_MAX_FRAME = 1522;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    PREAMBLE,
    DATA,
    DROP,
    STATUS
  } eth_rx_state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/crc32.sv
// Byte-wide Ethernet CRC-32 (reflected, poly 0xEDB88320); registered state,
// output presented complemented with the first FCS byte in the MSBs.
module crc32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rst,
  input  logic        vld,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  logic [31:0] st;
  logic [31:0] st_nxt;

  always_comb begin
    st_nxt = st ^ {24'd0, d};
    for (int unsigned i = 0; i < 8; i++) begin
      st_nxt = st_nxt[0] ? ((st_nxt >> 1) ^ 32'hEDB88320) : (st_nxt >> 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   st <= '1;
    else if (rst) st <= '1;
    else if (vld) st <= st_nxt;
  end

  assign crc = ~{st[7:0], st[15:8], st[23:16], st[31:24]};

endmodule

// File: rtl/eth_fcs_delay.sv
// 4-byte delay line holding back the trailing FCS; the tap reads the four
// held bytes with the oldest byte in the LSBs.
module eth_fcs_delay (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        full,
  output logic [31:0] tap
);

  logic [3:0][7:0] st;
  logic [3:0]      v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= '0;
      v  <= '0;
    end else if (clr) begin
      st <= '0;
      v  <= '0;
    end else if (push) begin
      st <= {st[2:0], din};
      v  <= {v[2:0], 1'b1};
    end
  end

  assign dout = st[3];
  assign full = v[3];
  assign tap  = {st[0], st[1], st[2], st[3]};

endmodule

// File: rtl/eth_rx_deframer.sv
// Ethernet RX deframer: preamble/SFD detect, byte assembly, FCS strip/check,
// per-frame status. Define ETH_RX_SHORT_PREAMBLE_EN to accept short preambles.
module eth_rx_deframer
  import eth_defs::*;
#(
  parameter int unsigned DW      = 2,
  parameter int unsigned MIN_LEN = ETH_MIN_FRAME,
  parameter int unsigned MAX_LEN = ETH_MAX_FRAME
) (
  input  logic          eth_clkin,
  input  logic          eth_rstn,
  input  logic          rx_dv,
  input  logic [DW-1:0] rx_d,
  output logic [7:0]    m_data,
  output logic          m_vld,
  output logic          m_sof,
  output logic          stat_vld,
  output logic          stat_ok,
  output logic          stat_crc_err,
  output logic          stat_short,
  output logic          stat_long,
  output logic          stat_align,
  output logic [10:0]   stat_len
);

  if (!(DW == 1 || DW == 2 || DW == 4 || DW == 8)) begin : g_bad_dw
    $error("eth_rx_deframer: DW must be 1, 2, 4 or 8");
  end
  if (MAX_LEN > 2047) begin : g_bad_max
    $error("eth_rx_deframer: MAX_LEN must be <= 2047");
  end

  localparam int unsigned SPB = 8 / DW;

  eth_rx_state_e state, state_nxt;
  logic [63:0] pre_sr;
  logic [7:0]  byte_sr, byte_nxt;
  logic [2:0]  cnt;
  logic [10:0] len;
  logic        align_r, sof_pend;
  logic        sfd_hit, in_data, adv, byte_done, len_full, push, over, emit, fall;
  logic        crc_rst, crc_bad, is_short, is_long;
  logic [7:0]  dly_dout;
  logic        dly_full;
  logic [31:0] dly_tap, crc_val;

`ifdef ETH_RX_SHORT_PREAMBLE_EN
  assign sfd_hit = (pre_sr[63:48] == ETH_PRE_SFD[63:48]);
`else
  assign sfd_hit = (pre_sr == ETH_PRE_SFD);
`endif

  // The match is seen a cycle after the SFD's last symbol, so that cycle
  // already carries the first data symbol and is treated as data.
  assign in_data   = rx_dv && (state == DATA || (state == PREAMBLE && sfd_hit));
  assign adv       = in_data || (rx_dv && state == DROP);
  assign byte_nxt  = 8'({rx_d, byte_sr} >> DW);
  assign byte_done = in_data && (cnt == 3'(SPB - 1));
  assign len_full  = (len == 11'(MAX_LEN));
  assign push      = byte_done && !len_full;
  assign over      = byte_done && len_full;
  assign emit      = push && dly_full;
  assign fall      = !rx_dv && (state == DATA || state == DROP);
  assign crc_rst   = rx_dv && (state == PREAMBLE) && sfd_hit;

  assign is_short = (len < 11'(MIN_LEN));
  assign is_long  = (len > 11'(MAX_LEN));
  assign crc_bad  = (len < 11'd4) || (dly_tap != bswap32(crc_val));

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_IDLE: if (!rx_dv) state_nxt = IDLE;
      IDLE:      if (rx_dv) state_nxt = PREAMBLE;
      PREAMBLE:  if (!rx_dv) state_nxt = IDLE;
                 else if (sfd_hit) state_nxt = DATA;
      DATA:      if (!rx_dv) state_nxt = STATUS;
                 else if (over) state_nxt = DROP;
      DROP:      if (!rx_dv) state_nxt = STATUS;
      STATUS:    state_nxt = IDLE;
      default:   state_nxt = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge eth_clkin or negedge eth_rstn) begin
    if (!eth_rstn) begin
      state        <= WAIT_IDLE;
      pre_sr       <= '0;
      byte_sr      <= '0;
      cnt          <= '0;
      len          <= '0;
      align_r      <= 1'b0;
      sof_pend     <= 1'b0;
      m_data       <= '0;
      m_vld        <= 1'b0;
      m_sof        <= 1'b0;
      stat_vld     <= 1'b0;
      stat_ok      <= 1'b0;
      stat_crc_err <= 1'b0;
      stat_short   <= 1'b0;
      stat_long    <= 1'b0;
      stat_align   <= 1'b0;
      stat_len     <= '0;
    end else begin
      state <= state_nxt;

      if (rx_dv && (state == IDLE || (state == PREAMBLE && !sfd_hit)))
        pre_sr <= {rx_d, pre_sr[63:DW]};
      else
        pre_sr <= '0;

      if (state == IDLE) begin
        cnt      <= '0;
        len      <= '0;
        byte_sr  <= '0;
        sof_pend <= 1'b1;
      end else begin
        if (adv) begin
          cnt     <= (cnt == 3'(SPB - 1)) ? 3'd0 : cnt + 3'd1;
          byte_sr <= byte_nxt;
        end
        if (push)      len <= len + 11'd1;
        else if (over) len <= 11'(MAX_LEN + 1);
      end

      if (fall) align_r <= (cnt != 3'd0);

      m_vld <= emit;
      m_sof <= emit && sof_pend;
      if (emit) begin
        m_data   <= dly_dout;
        sof_pend <= 1'b0;
      end

      stat_vld <= (state == STATUS);
      if (state == STATUS) begin
        stat_len     <= len;
        stat_short   <= is_short;
        stat_long    <= is_long;
        stat_crc_err <= crc_bad;
        stat_align   <= align_r;
        stat_ok      <= !(is_short || is_long || crc_bad || align_r);
      end
    end
  end

  eth_fcs_delay u_fcs_delay (
    .clk   (eth_clkin),
    .rst_n (eth_rstn),
    .clr   (state == IDLE),
    .push  (push),
    .din   (byte_nxt),
    .dout  (dly_dout),
    .full  (dly_full),
    .tap   (dly_tap)
  );

  crc32 u_crc32 (
    .clk   (eth_clkin),
    .rst_n (eth_rstn),
    .rst   (crc_rst),
    .vld   (emit),
    .d     (dly_dout),
    .crc   (crc_val)
  );

endmodule
